// File: rtl/bram_boot_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bram_boot_ctrl_pkg
// Brief    : Shared types and constants for the BRAM boot controller.
// Revision : 1.0 - initial release
// ============================================================================
package bram_boot_ctrl_pkg;

    // Controller states; the encoding is visible on state_o.
    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } boot_state_t;

    // Full-word byte enable used for every host write.
    localparam logic [3:0]  WE_ALL       = 4'hF;

    // Address presented to the BRAM while the core is held in reset.
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

endpackage : bram_boot_ctrl_pkg
`default_nettype wire

// File: rtl/boot_addr_check.sv
`default_nettype none
// ============================================================================
// Module   : boot_addr_check
// Brief    : Combinational legality check of a host byte address against the
//            instruction BRAM depth (word aligned and inside MEM_WORDS).
// Revision : 1.0 - initial release
// ============================================================================
module boot_addr_check #(
    parameter int MEM_WORDS = 1024
) (
    input  logic [31:0] i_addr,
    output logic        o_legal
);

    logic w_aligned;
    logic w_in_range;

    // Word index is compared zero-extended so any MEM_WORDS fits the compare.
    assign w_aligned  = (i_addr[1:0] == 2'b00);
    assign w_in_range = ({2'b00, i_addr[31:2]} < 32'(MEM_WORDS));
    assign o_legal    = w_aligned & w_in_range;

endmodule : boot_addr_check
`default_nettype wire

// File: rtl/bram_boot_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bram_boot_ctrl
// Brief    : Loads a program image from a host stream into the instruction
//            BRAM, then releases the core and hands it the BRAM read port.
//            A reload request stops the core and re-enters load mode.
// Revision : 1.0 - initial release
// ============================================================================
module bram_boot_ctrl
    import bram_boot_ctrl_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             host_valid,
    output logic             host_ready,
    input  logic [31:0]      host_addr,
    input  logic [31:0]      host_data,
    input  logic             host_last,
    input  logic             reload_req,
    input  logic [31:0]      core_pc,
    output logic             core_rst,
    output logic             bram_en,
    output logic [3:0]       bram_we,
    output logic [31:0]      bram_addr,
    output logic [31:0]      bram_din,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] word_cnt,
    output logic             err
);

    boot_state_t      r_state;
    boot_state_t      w_next_state;
    logic             w_legal;
    logic             w_handshake;
    logic             w_write;
    logic             w_reject;
    logic [CNT_W-1:0] r_word_cnt;
    logic             r_err;

    boot_addr_check #(
        .MEM_WORDS (MEM_WORDS)
    ) u_addr_check (
        .i_addr  (host_addr),
        .o_legal (w_legal)
    );

    // While reset is high nothing may reach the BRAM even though the state
    // already reads LOAD, so the handshake is masked by reset.
    assign w_handshake = host_valid & host_ready & ~reset;

    // State register; asynchronous reset lands directly in LOAD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and BRAM port mux.
    always_comb begin
        w_next_state = r_state;
        host_ready   = 1'b0;
        core_rst     = 1'b1;
        bram_en      = 1'b0;
        bram_we      = 4'h0;
        bram_addr    = 32'h0;
        bram_din     = 32'h0;
        w_write      = 1'b0;
        w_reject     = 1'b0;
        case (r_state)
            ST_LOAD: begin
                host_ready = 1'b1;
                if (w_handshake) begin
                    if (w_legal) begin
                        w_write   = 1'b1;
                        bram_en   = 1'b1;
                        bram_we   = WE_ALL;
                        bram_addr = host_addr;
                        bram_din  = host_data;
                    end else begin
                        w_reject  = 1'b1;
                    end
                    // The image ends on last even if that word was rejected.
                    if (host_last) begin
                        w_next_state = ST_PRIME;
                    end
                end
            end
            ST_PRIME: begin
                // Prefetch the reset vector to cover the BRAM read latency.
                bram_en      = 1'b1;
                bram_addr    = RESET_VECTOR;
                w_next_state = ST_RUN;
            end
            ST_RUN: begin
                core_rst  = 1'b0;
                bram_en   = 1'b1;
                bram_addr = core_pc;
                if (reload_req) begin
                    w_next_state = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                w_next_state = ST_LOAD;
            end
            default: begin
                w_next_state = ST_LOAD;
            end
        endcase
    end

    // Saturating written-word counter, cleared on the way back into LOAD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_word_cnt <= '0;
        end else if (r_state == ST_FLUSH) begin
            r_word_cnt <= '0;
        end else if (w_write && (r_word_cnt != {CNT_W{1'b1}})) begin
            r_word_cnt <= r_word_cnt + 1'b1;
        end
    end

    // Sticky error flag; only reset clears it, a reload keeps it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_reject) begin
            r_err <= 1'b1;
        end
    end

    assign state_o  = r_state;
    assign word_cnt = r_word_cnt;
    assign err      = r_err;

endmodule : bram_boot_ctrl
`default_nettype wire

// File: tb/tb_bram_boot_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_boot_ctrl
// Brief    : Self-checking bench for bram_boot_ctrl. Expected BRAM writes are
//            queued when host words are offered and popped by a monitor when
//            the DUT writes; state/counter checks are inline in each task.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram_boot_ctrl;

    logic        clk;
    logic        reset;
    logic        host_valid;
    logic [31:0] host_addr;
    logic [31:0] host_data;
    logic        host_last;
    logic        reload_req;
    logic [31:0] core_pc;

    logic        host_ready;
    logic        core_rst;
    logic        bram_en;
    logic [3:0]  bram_we;
    logic [31:0] bram_addr;
    logic [31:0] bram_din;
    logic [1:0]  state_o;
    logic [15:0] word_cnt;
    logic        err;

    logic        s_host_ready;
    logic        s_core_rst;
    logic        s_bram_en;
    logic [3:0]  s_bram_we;
    logic [31:0] s_bram_addr;
    logic [31:0] s_bram_din;
    logic [1:0]  s_state_o;
    logic [1:0]  s_word_cnt;
    logic        s_err;

    int          vectors;
    int          miscompares;
    logic [31:0] sb_addr[$];
    logic [31:0] sb_data[$];

    bram_boot_ctrl #(.MEM_WORDS(1024), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .host_valid(host_valid), .host_ready(host_ready),
        .host_addr(host_addr), .host_data(host_data), .host_last(host_last),
        .reload_req(reload_req), .core_pc(core_pc), .core_rst(core_rst),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_din(bram_din), .state_o(state_o), .word_cnt(word_cnt), .err(err)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation.
    bram_boot_ctrl #(.MEM_WORDS(1024), .CNT_W(2)) u_dut_sat (
        .clk(clk), .reset(reset), .host_valid(host_valid), .host_ready(s_host_ready),
        .host_addr(host_addr), .host_data(host_data), .host_last(host_last),
        .reload_req(reload_req), .core_pc(core_pc), .core_rst(s_core_rst),
        .bram_en(s_bram_en), .bram_we(s_bram_we), .bram_addr(s_bram_addr),
        .bram_din(s_bram_din), .state_o(s_state_o), .word_cnt(s_word_cnt), .err(s_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor: every full-word write must match the head of the queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (bram_we == 4'hF) begin
                vectors++;
                if (sb_addr.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_write: addr=%h din=%h, none expected", bram_addr, bram_din);
                end else begin
                    logic [31:0] ea;
                    logic [31:0] ed;
                    ea = sb_addr.pop_front();
                    ed = sb_data.pop_front();
                    if (bram_addr !== ea || bram_din !== ed || bram_en !== 1'b1) begin
                        miscompares++;
                        $display("FAIL write_data: got en=%b addr=%h din=%h, expected en=1 addr=%h din=%h",
                                 bram_en, bram_addr, bram_din, ea, ed);
                    end
                end
            end else if (bram_we !== 4'h0) begin
                vectors++;
                miscompares++;
                $display("FAIL write_enable: got we=%h, expected 0 or F", bram_we);
            end else if (bram_din !== 32'h0) begin
                vectors++;
                miscompares++;
                $display("FAIL din_idle: got din=%h with we=0, expected 0", bram_din);
            end
        end
    end

    task automatic send_word(input logic [31:0] a, input logic [31:0] d,
                             input logic l, input logic legal);
        @(posedge clk);
        #1;
        host_valid = 1'b1;
        host_addr  = a;
        host_data  = d;
        host_last  = l;
        if (legal) begin
            sb_addr.push_back(a);
            sb_data.push_back(d);
        end
        @(negedge clk);
        vectors++;
        if (host_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL host_ready_load: got %b, expected 1 (addr %h)", host_ready, a);
        end
    endtask

    task automatic go_idle();
        @(posedge clk);
        #1;
        host_valid = 1'b0;
        host_last  = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        vectors++;
        if (state_o !== 2'd0 || word_cnt !== 16'd0 || err !== 1'b0 || core_rst !== 1'b1 ||
            host_ready !== 1'b1 || bram_en !== 1'b0 || bram_we !== 4'h0 ||
            bram_addr !== 32'h0 || bram_din !== 32'h0) begin
            miscompares++;
            $display("FAIL %s: got st=%0d cnt=%0d err=%b crst=%b rdy=%b en=%b we=%h addr=%h din=%h, expected 0 0 0 1 1 0 0 0 0",
                     tag, state_o, word_cnt, err, core_rst, host_ready, bram_en, bram_we, bram_addr, bram_din);
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        host_valid = 1'b1;
        host_addr  = 32'h4;
        host_data  = 32'h1234_5678;
        host_last  = 1'b0;
        reload_req = 1'b0;
        core_pc    = 32'h0;
        #2;
        check_reset_values("reset_state");
        @(negedge clk);
        #2;
        host_valid = 1'b0;
        reset      = 1'b0;
    endtask

    task automatic test_illegal();
        send_word(32'h0000_0002, 32'hBAD0_0002, 1'b0, 1'b0);
        send_word(32'h0000_1000, 32'hBAD0_1000, 1'b0, 1'b0);
        go_idle();
        @(negedge clk);
        vectors++;
        if (err !== 1'b1 || word_cnt !== 16'd0 || state_o !== 2'd0) begin
            miscompares++;
            $display("FAIL illegal_words: got err=%b cnt=%0d st=%0d, expected 1 0 0", err, word_cnt, state_o);
        end
    endtask

    task automatic test_load();
        core_pc = 32'h40;
        send_word(32'h0, 32'h0050_0093, 1'b0, 1'b1);
        send_word(32'h4, 32'h00A0_0113, 1'b0, 1'b1);
        send_word(32'h8, 32'h0020_81B3, 1'b1, 1'b1);
        go_idle();
        @(negedge clk);
        vectors++;
        if (state_o !== 2'd1 || word_cnt !== 16'd3 || bram_en !== 1'b1 || bram_we !== 4'h0 ||
            bram_addr !== 32'h0 || core_rst !== 1'b1 || host_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL prime: got st=%0d cnt=%0d en=%b we=%h addr=%h crst=%b rdy=%b, expected 1 3 1 0 0 1 0",
                     state_o, word_cnt, bram_en, bram_we, bram_addr, core_rst, host_ready);
        end
        @(negedge clk);
        vectors++;
        if (state_o !== 2'd2 || bram_addr !== 32'h40 || core_rst !== 1'b0 || bram_en !== 1'b1) begin
            miscompares++;
            $display("FAIL run_entry: got st=%0d addr=%h crst=%b en=%b, expected 2 00000040 0 1",
                     state_o, bram_addr, core_rst, bram_en);
        end
        vectors++;
        if (sb_addr.size() != 0) begin
            miscompares++;
            $display("FAIL load_writes: got %0d writes outstanding, expected 0", sb_addr.size());
        end
    endtask

    task automatic test_backpressure();
        #1;
        host_valid = 1'b1;
        host_addr  = 32'h8;
        host_data  = 32'hDEAD_BEEF;
        host_last  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (host_ready !== 1'b0 || bram_we !== 4'h0 || state_o !== 2'd2) begin
                miscompares++;
                $display("FAIL backpressure[%0d]: got rdy=%b we=%h st=%0d, expected 0 0 2",
                         i, host_ready, bram_we, state_o);
            end
        end
    endtask

    task automatic test_reload();
        @(posedge clk);
        #1;
        reload_req = 1'b1;
        core_pc    = 32'h10;
        @(negedge clk);
        vectors++;
        if (state_o !== 2'd2 || bram_addr !== 32'h10) begin
            miscompares++;
            $display("FAIL run_pc: got st=%0d addr=%h, expected 2 00000010", state_o, bram_addr);
        end
        @(posedge clk);
        #1;
        reload_req = 1'b0;
        // The held word is accepted once LOAD is re-entered.
        sb_addr.push_back(32'h8);
        sb_data.push_back(32'hDEAD_BEEF);
        @(negedge clk);
        vectors++;
        if (state_o !== 2'd3 || core_rst !== 1'b1 || bram_en !== 1'b0 || host_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL flush: got st=%0d crst=%b en=%b rdy=%b, expected 3 1 0 0",
                     state_o, core_rst, bram_en, host_ready);
        end
        @(negedge clk);
        vectors++;
        if (state_o !== 2'd0 || word_cnt !== 16'd0 || err !== 1'b1 || host_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reload_load: got st=%0d cnt=%0d err=%b rdy=%b, expected 0 0 1 1",
                     state_o, word_cnt, err, host_ready);
        end
        go_idle();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) begin
            send_word(32'h10 + 32'(4 * i), 32'hA000_0000 + 32'(i), (i == 4), 1'b1);
        end
        go_idle();
        @(negedge clk);
        vectors++;
        if (state_o !== 2'd1 || word_cnt !== 16'd6) begin
            miscompares++;
            $display("FAIL count_wide: got st=%0d cnt=%0d, expected 1 6", state_o, word_cnt);
        end
        vectors++;
        if (s_word_cnt !== 2'd3) begin
            miscompares++;
            $display("FAIL count_saturate: got %0d, expected 3", s_word_cnt);
        end
        @(negedge clk);
        vectors++;
        if (state_o !== 2'd2 || sb_addr.size() != 0) begin
            miscompares++;
            $display("FAIL sat_run: got st=%0d pending=%0d, expected 2 0", state_o, sb_addr.size());
        end
    endtask

    task automatic test_async_reset();
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("async_reset");
        @(negedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (state_o !== 2'd0 || core_rst !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset: got st=%0d crst=%b, expected 0 1", state_o, core_rst);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_illegal();
        test_load();
        test_backpressure();
        test_reload();
        test_saturation();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule : tb_bram_boot_ctrl
`default_nettype wire
